decoder_nxm_seq: RTL and testbench

Parametrised, registered binary-to-one-hot decoder that replaces the fixed 2-to-4 combinational decoder in designs that need a held, handshaked select output. Codes are accepted over a valid/ready interface and decoded into a registered one-hot vector of `N_OUT` lines. An optional scan mode steps the active line through every output for a programmable dwell time, for example for LED/digit multiplexing. The block sits between a control FSM and the downstream select/enable lines it drives.

---
 rtl/decoder_nxm_seq.sv | 147 ++++++++++++++
 tb/tb_decoder_nxm_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nxm_seq.sv
// Registered binary-to-one-hot decoder with a valid/ready code input and an optional
// scan mode that rotates the active line; scan logic is compiled in only with DECODER_SCAN_EN.
module decoder_nxm_seq #(
   parameter int SEL_W = 2,
   parameter int N_OUT = 4,
   parameter int DWELL = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [SEL_W-1:0] s,
   input  logic             scan_start,
   input  logic             scan_stop,
   output logic [N_OUT-1:0] o,
   output logic             o_valid,
   output logic             busy,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

   state_t           state, state_n;
   logic [N_OUT-1:0] o_n;
   logic [N_OUT-1:0] code_dec;
   logic             o_valid_n;
   logic             err_n;
   logic             code_ok;

   // Codes at or above N_OUT have no line to drive and are flagged instead.
   always_comb begin
      code_ok = ({{(32-SEL_W){1'b0}}, s} < 32'(N_OUT));
      for (int i = 0; i < N_OUT; i++) begin
         code_dec[i] = (s == SEL_W'(i));
      end
   end

`ifdef DECODER_SCAN_EN
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int LW = $clog2(N_OUT);

   logic [DW-1:0] dwell, dwell_n;
   logic [LW-1:0] line, line_n;

   assign s_ready = en && (state != SCAN);
   assign busy    = (state == SCAN);
`else
   logic unused_scan;

   assign unused_scan = ^{scan_start, scan_stop};
   localparam int unused_dwell = DWELL;

   assign s_ready = en;
   assign busy    = 1'b0;
`endif

   // Branch order encodes the per-cycle priority: enable, stop, start, then accept.
   always_comb begin
      state_n   = state;
      o_n       = o;
      o_valid_n = o_valid;
      err_n     = 1'b0;
`ifdef DECODER_SCAN_EN
      dwell_n   = dwell;
      line_n    = line;
`endif
      if (!en) begin
         state_n   = IDLE;
         o_n       = '0;
         o_valid_n = 1'b0;
`ifdef DECODER_SCAN_EN
         dwell_n   = '0;
         line_n    = '0;
`endif
      end
`ifdef DECODER_SCAN_EN
      else if (state == SCAN) begin
         if (scan_stop) begin
            state_n   = IDLE;
            o_n       = '0;
            o_valid_n = 1'b0;
            dwell_n   = '0;
            line_n    = '0;
         end else if (dwell == DW'(DWELL - 1)) begin
            dwell_n = '0;
            if (line == LW'(N_OUT - 1)) begin
               line_n = '0;
            end else begin
               line_n = line + LW'(1);
            end
            for (int i = 0; i < N_OUT; i++) begin
               o_n[i] = (line_n == LW'(i));
            end
         end else begin
            dwell_n = dwell + DW'(1);
         end
      end else if (scan_start) begin
         state_n   = SCAN;
         o_n       = '0;
         o_n[0]    = 1'b1;
         o_valid_n = 1'b1;
         dwell_n   = '0;
         line_n    = '0;
      end
`endif
      else if (s_valid && s_ready) begin
         if (code_ok) begin
            state_n   = HOLD;
            o_n       = code_dec;
            o_valid_n = 1'b1;
         end else begin
            state_n   = IDLE;
            o_n       = '0;
            o_valid_n = 1'b0;
            err_n     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         o       <= '0;
         o_valid <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         o       <= o_n;
         o_valid <= o_valid_n;
         err     <= err_n;
      end
   end

`ifdef DECODER_SCAN_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell <= '0;
         line  <= '0;
      end else begin
         dwell <= dwell_n;
         line  <= line_n;
      end
   end
`endif

endmodule

// File: tb/tb_decoder_nxm_seq.sv
// Scoreboard bench for decoder_nxm_seq (SEL_W=3, N_OUT=5, DWELL=3); scan scenarios
// run when DECODER_SCAN_EN is defined, the scan-disabled scenario otherwise.
module tb_decoder_nxm_seq;

   localparam int SEL_W = 3;
   localparam int N_OUT = 5;
   localparam int DWELL = 3;

   typedef struct packed {
      logic [N_OUT-1:0] o;
      logic             ov;
      logic             err;
      logic             busy;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             s_valid;
   logic             s_ready;
   logic [SEL_W-1:0] s;
   logic             scan_start;
   logic             scan_stop;
   logic [N_OUT-1:0] o;
   logic             o_valid;
   logic             busy;
   logic             err;

   int   passed = 0;
   int   total  = 0;
   exp_t sb[$];
   exp_t e;

   decoder_nxm_seq #(.SEL_W(SEL_W), .N_OUT(N_OUT), .DWELL(DWELL)) dut (
      .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready), .s(s),
      .scan_start(scan_start), .scan_stop(scan_stop), .o(o), .o_valid(o_valid),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [N_OUT-1:0] onehot(input int k);
      logic [N_OUT-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b0; s_valid = 1'b0; s = '0; scan_start = 1'b0; scan_stop = 1'b0;
      repeat (3) tick();
      total++;
      if ({o, o_valid, err, busy} !== {{N_OUT{1'b0}}, 3'b000})
         $display("[TB] FAIL reset_outputs: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, {{N_OUT{1'b0}}, 3'b000});
      else passed++;
      total++;
      if (s_ready !== 1'b0) $display("[TB] FAIL reset_ready_en0: s_ready got %b required 0", s_ready);
      else passed++;
      en = 1'b1;
      #3 rst = 1'b0;
      #1;
      total++;
      if (s_ready !== 1'b1) $display("[TB] FAIL ready_after_reset: s_ready got %b required 1", s_ready);
      else passed++;
   endtask

   task automatic test_single_hold;
      s = 3'd2; s_valid = 1'b1;
      sb.push_back('{o: onehot(2), ov: 1'b1, err: 1'b0, busy: 1'b0});
      tick();
      s_valid = 1'b0;
      e = sb.pop_front();
      total++;
      if ({o, o_valid, err, busy} !== e)
         $display("[TB] FAIL single_decode: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, e);
      else passed++;
      for (int k = 0; k < 10; k++) begin
         sb.push_back('{o: onehot(2), ov: 1'b1, err: 1'b0, busy: 1'b0});
         tick();
         e = sb.pop_front();
         total++;
         if ({o, o_valid, err, busy} !== e)
            $display("[TB] FAIL hold_cycle%0d: o/o_valid/err/busy got %b required %b", k, {o, o_valid, err, busy}, e);
         else passed++;
      end
   endtask

   task automatic test_back_to_back;
      for (int c = 0; c < N_OUT; c++) begin
         s = SEL_W'(c); s_valid = 1'b1;
         total++;
         if (s_ready !== 1'b1) $display("[TB] FAIL b2b_ready%0d: s_ready got %b required 1", c, s_ready);
         else passed++;
         sb.push_back('{o: onehot(c), ov: 1'b1, err: 1'b0, busy: 1'b0});
         tick();
         e = sb.pop_front();
         total++;
         if ({o, o_valid, err, busy} !== e)
            $display("[TB] FAIL b2b_code%0d: o/o_valid/err/busy got %b required %b", c, {o, o_valid, err, busy}, e);
         else passed++;
      end
      s_valid = 1'b0;
   endtask

   task automatic test_out_of_range;
      s = 3'd6; s_valid = 1'b1;
      sb.push_back('{o: '0, ov: 1'b0, err: 1'b1, busy: 1'b0});
      tick();
      s_valid = 1'b0;
      e = sb.pop_front();
      total++;
      if ({o, o_valid, err, busy} !== e)
         $display("[TB] FAIL oor_err_pulse: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, e);
      else passed++;
      sb.push_back('{o: '0, ov: 1'b0, err: 1'b0, busy: 1'b0});
      tick();
      e = sb.pop_front();
      total++;
      if ({o, o_valid, err, busy} !== e)
         $display("[TB] FAIL oor_err_cleared: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, e);
      else passed++;
      s = 3'd5; s_valid = 1'b1;
      sb.push_back('{o: '0, ov: 1'b0, err: 1'b1, busy: 1'b0});
      tick();
      s_valid = 1'b0;
      e = sb.pop_front();
      total++;
      if ({o, o_valid, err, busy} !== e)
         $display("[TB] FAIL oor_boundary5: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, e);
      else passed++;
   endtask

   task automatic test_stop_ignored;
      s = 3'd4; s_valid = 1'b1;
      sb.push_back('{o: onehot(4), ov: 1'b1, err: 1'b0, busy: 1'b0});
      tick();
      s_valid = 1'b0;
      e = sb.pop_front();
      total++;
      if ({o, o_valid, err, busy} !== e)
         $display("[TB] FAIL top_code4: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, e);
      else passed++;
      scan_stop = 1'b1;
      sb.push_back('{o: onehot(4), ov: 1'b1, err: 1'b0, busy: 1'b0});
      tick();
      scan_stop = 1'b0;
      e = sb.pop_front();
      total++;
      if ({o, o_valid, err, busy} !== e)
         $display("[TB] FAIL stop_in_hold: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, e);
      else passed++;
   endtask

   task automatic test_en_low;
      en = 1'b0; s = 3'd1; s_valid = 1'b1; scan_stop = 1'b1;
      #1;
      total++;
      if (s_ready !== 1'b0) $display("[TB] FAIL en_low_ready: s_ready got %b required 0", s_ready);
      else passed++;
      sb.push_back('{o: '0, ov: 1'b0, err: 1'b0, busy: 1'b0});
      tick();
      en = 1'b1; s_valid = 1'b0; scan_stop = 1'b0;
      e = sb.pop_front();
      total++;
      if ({o, o_valid, err, busy} !== e)
         $display("[TB] FAIL en_low_clear: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, e);
      else passed++;
   endtask

`ifdef DECODER_SCAN_EN
   task automatic test_scan;
      s = 3'd1; s_valid = 1'b1; scan_start = 1'b1;
      total++;
      if (s_ready !== 1'b1) $display("[TB] FAIL scan_start_ready: s_ready got %b required 1", s_ready);
      else passed++;
      for (int k = 0; k < 16; k++)
         sb.push_back('{o: onehot((k / DWELL) % N_OUT), ov: 1'b1, err: 1'b0, busy: 1'b1});
      tick();
      s_valid = 1'b0; scan_start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) tick();
         scan_start = 1'b0;
         e = sb.pop_front();
         total++;
         if ({o, o_valid, err, busy} !== e)
            $display("[TB] FAIL scan_step%0d: o/o_valid/err/busy got %b required %b", k, {o, o_valid, err, busy}, e);
         else passed++;
         total++;
         if (s_ready !== 1'b0) $display("[TB] FAIL scan_ready%0d: s_ready got %b required 0", k, s_ready);
         else passed++;
         if (k == 7) scan_start = 1'b1;
      end
      scan_stop = 1'b1;
      sb.push_back('{o: '0, ov: 1'b0, err: 1'b0, busy: 1'b0});
      tick();
      scan_stop = 1'b0;
      e = sb.pop_front();
      total++;
      if ({o, o_valid, err, busy} !== e)
         $display("[TB] FAIL scan_stop: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, e);
      else passed++;
      total++;
      if (s_ready !== 1'b1) $display("[TB] FAIL stop_ready: s_ready got %b required 1", s_ready);
      else passed++;
   endtask

   task automatic test_reset_mid_scan;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      repeat (6) tick();
      sb.push_back('{o: onehot(2), ov: 1'b1, err: 1'b0, busy: 1'b1});
      e = sb.pop_front();
      total++;
      if ({o, o_valid, err, busy} !== e)
         $display("[TB] FAIL mid_scan_line2: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, e);
      else passed++;
      #2 rst = 1'b1;
      #1;
      total++;
      if ({o, o_valid, err, busy} !== {{N_OUT{1'b0}}, 3'b000})
         $display("[TB] FAIL async_reset: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, {{N_OUT{1'b0}}, 3'b000});
      else passed++;
      #2 rst = 1'b0;
      #1;
      total++;
      if (s_ready !== 1'b1) $display("[TB] FAIL ready_after_async: s_ready got %b required 1", s_ready);
      else passed++;
      s = 3'd3; s_valid = 1'b1;
      sb.push_back('{o: onehot(3), ov: 1'b1, err: 1'b0, busy: 1'b0});
      tick();
      s_valid = 1'b0;
      e = sb.pop_front();
      total++;
      if ({o, o_valid, err, busy} !== e)
         $display("[TB] FAIL first_accept: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, e);
      else passed++;
   endtask
`else
   task automatic test_scan_disabled;
      s = 3'd0; s_valid = 1'b1;
      sb.push_back('{o: onehot(0), ov: 1'b1, err: 1'b0, busy: 1'b0});
      tick();
      s_valid = 1'b0;
      scan_start = 1'b1;
      sb.push_back('{o: onehot(0), ov: 1'b1, err: 1'b0, busy: 1'b0});
      sb.push_back('{o: onehot(0), ov: 1'b1, err: 1'b0, busy: 1'b0});
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         if (k == 2) scan_start = 1'b0;
         e = sb.pop_front();
         total++;
         if ({o, o_valid, err, busy} !== e)
            $display("[TB] FAIL noscan_hold%0d: o/o_valid/err/busy got %b required %b", k, {o, o_valid, err, busy}, e);
         else passed++;
         total++;
         if (s_ready !== 1'b1) $display("[TB] FAIL noscan_ready%0d: s_ready got %b required 1", k, s_ready);
         else passed++;
      end
      scan_start = 1'b0;
      s = 3'd3; s_valid = 1'b1;
      sb.push_back('{o: onehot(3), ov: 1'b1, err: 1'b0, busy: 1'b0});
      tick();
      s_valid = 1'b0;
      e = sb.pop_front();
      total++;
      if ({o, o_valid, err, busy} !== e)
         $display("[TB] FAIL noscan_code3: o/o_valid/err/busy got %b required %b", {o, o_valid, err, busy}, e);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_single_hold();
      test_back_to_back();
      test_out_of_range();
      test_stop_ignored();
      test_en_low();
`ifdef DECODER_SCAN_EN
      test_scan();
      test_reset_mid_scan();
`else
      test_scan_disabled();
`endif
      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
